// File: rtl/period_meter.sv
// period_meter: measures the period of a slow square wave in clk cycles and flags loss of signal.
// Optional macro HIGH_TIME_EN adds the high_time output (high-phase length of each period).
module period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
`ifdef HIGH_TIME_EN
  ,
  output logic [WIDTH-1:0] high_time
`endif
);

  localparam logic [WIDTH-1:0] LP_TIMEOUT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_cnt;
  logic             w_rise;
  logic             w_active;
  logic             w_load;
  logic             w_tmo_hit;

  // s1 is the metastability stage; edges are taken from the settled s2/s3 pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_active  = (r_state != ST_IDLE);
  assign w_load    = w_active & w_rise;
  assign w_tmo_hit = w_active & ~w_rise & (r_cnt == LP_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_ARMED;
      end
      default: begin
        if (w_rise)         w_state_nxt = ST_LOCKED;
        else if (w_tmo_hit) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A rise always restarts counting at 1 so that cnt equals the period on the next rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= w_load;
      timeout      <= w_tmo_hit;
      if (w_rise)                     r_cnt <= LP_ONE;
      else if (w_tmo_hit || !w_active) r_cnt <= '0;
      else                            r_cnt <= r_cnt + LP_ONE;
      if (w_load) begin
        period <= r_cnt;
        locked <= 1'b1;
      end else if (w_tmo_hit) begin
        locked <= 1'b0;
      end
    end
  end

`ifdef HIGH_TIME_EN
  logic             w_fall;
  logic [WIDTH-1:0] r_hcnt;
  logic             r_fall_seen;

  assign w_fall = ~r_s2 & r_s3;

  // Without a fall between two rises the whole period counts as high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcnt      <= '0;
      r_fall_seen <= 1'b0;
      high_time   <= '0;
    end else begin
      if (w_rise) begin
        r_fall_seen <= 1'b0;
        if (w_active) high_time <= r_fall_seen ? r_hcnt : r_cnt;
      end else if (w_fall && w_active) begin
        r_hcnt      <= r_cnt;
        r_fall_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: two instances (short and long timeout) against an elapsed-time model.
module tb_period_meter;
  localparam int W    = 16;
  localparam int TO_A = 20;
  localparam int TO_B = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic         sig_in;
  logic [W-1:0] period_a, period_b;
  logic         pv_a, pv_b, lk_a, lk_b, to_a, to_b;
`ifdef HIGH_TIME_EN
  logic [W-1:0] high_a, high_b;
`endif

  period_meter #(.WIDTH(W), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_in), .period(period_a),
    .period_valid(pv_a), .locked(lk_a), .timeout(to_a)
`ifdef HIGH_TIME_EN
    , .high_time(high_a)
`endif
  );

  period_meter #(.WIDTH(W), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_in), .period(period_b),
    .period_valid(pv_b), .locked(lk_b), .timeout(to_b)
`ifdef HIGH_TIME_EN
    , .high_time(high_b)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: sampled input history plus time elapsed since the reference rise
  bit h0, h1, h2, h3;
  bit m_ref[2];
  int m_age[2];
  int e_period[2];
  bit e_valid[2], e_to[2], e_lock[2];
`ifdef HIGH_TIME_EN
  int m_fall[2];
  int e_high[2];
`endif

  int n_pass, n_checks;
  int since_valid_a, to_count_a, valid_count_a;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_period;
    int exp_high;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
  endtask

  function automatic void model_clear();
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ref[i] = 1'b0; m_age[i] = 0; e_period[i] = 0;
      e_valid[i] = 1'b0; e_to[i] = 1'b0; e_lock[i] = 1'b0;
`ifdef HIGH_TIME_EN
      m_fall[i] = -1; e_high[i] = 0;
`endif
    end
  endfunction

  function automatic void model_advance(input int i, input int tmo, input bit rise, input bit fall);
    e_valid[i] = 1'b0;
    e_to[i]    = 1'b0;
    if (m_ref[i]) m_age[i]++;
    if (rise) begin
      if (m_ref[i]) begin
        e_valid[i]  = 1'b1;
        e_period[i] = m_age[i];
        e_lock[i]   = 1'b1;
`ifdef HIGH_TIME_EN
        e_high[i] = (m_fall[i] >= 0) ? m_fall[i] : m_age[i];
`endif
      end
      m_ref[i] = 1'b1;
      m_age[i] = 0;
`ifdef HIGH_TIME_EN
      m_fall[i] = -1;
`endif
    end else if (m_ref[i] && m_age[i] == tmo) begin
      e_to[i]   = 1'b1;
      e_lock[i] = 1'b0;
      m_ref[i]  = 1'b0;
    end else if (fall && m_ref[i]) begin
`ifdef HIGH_TIME_EN
      m_fall[i] = m_age[i];
`endif
    end
  endfunction

  task automatic compare_all();
    check("period_a", int'(period_a), e_period[0]);
    check("valid_a", int'(pv_a), int'(e_valid[0]));
    check("locked_a", int'(lk_a), int'(e_lock[0]));
    check("timeout_a", int'(to_a), int'(e_to[0]));
    check("period_b", int'(period_b), e_period[1]);
    check("valid_b", int'(pv_b), int'(e_valid[1]));
    check("locked_b", int'(lk_b), int'(e_lock[1]));
    check("timeout_b", int'(to_b), int'(e_to[1]));
`ifdef HIGH_TIME_EN
    check("high_a", int'(high_a), e_high[0]);
    check("high_b", int'(high_b), e_high[1]);
    if (pv_b) check("high_le_period_b", int'(high_b <= period_b), 1);
`endif
  endtask

  task automatic step(input bit v);
    bit rise, fall;
    sig_in = v;
    @(posedge clk);
    h3 = h2; h2 = h1; h1 = h0; h0 = v;
    rise = h2 & ~h3;
    fall = ~h2 & h3;
    model_advance(0, TO_A, rise, fall);
    model_advance(1, TO_B, rise, fall);
    #1;
    compare_all();
    since_valid_a++;
    if (pv_a) begin
      since_valid_a = 0;
      valid_count_a++;
    end
    if (to_a) to_count_a++;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_clear();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected below 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    n_pass = 0; n_checks = 0;
    since_valid_a = 0; to_count_a = 0; valid_count_a = 0;
    tbl[0] = '{5, 5, 4, 10, 5};
    tbl[1] = '{3, 4, 4, 7, 3};
    tbl[2] = '{10, 10, 3, 20, 10};
    tbl[3] = '{1, 6, 3, 7, 1};
    tbl[4] = '{12, 3, 3, 15, 12};

    reset  = 1'b1;
    sig_in = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Table of steady square waves; consecutive entries also change the period mid-stream
    for (int t = 0; t < 5; t++) begin
      to_count_a = 0;
      wave(tbl[t].hi, tbl[t].lo, tbl[t].n);
      check("tbl_period_a", int'(period_a), tbl[t].exp_period);
      check("tbl_period_b", int'(period_b), tbl[t].exp_period);
      check("tbl_locked_a", int'(lk_a), 1);
      check("tbl_no_timeout_a", to_count_a, 0);
`ifdef HIGH_TIME_EN
      check("tbl_high_a", int'(high_a), tbl[t].exp_high);
`endif
    end

    // Signal stops: timeout TO_A cycles after the last strobe, then restart
    wave(5, 5, 3);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step(1'b0);
      if (to_a) got = 1'b1;
    end
    check("timeout_seen", int'(got), 1);
    check("timeout_delay", since_valid_a, TO_A);
    check("timeout_locked", int'(lk_a), 0);
    check("timeout_period_kept", int'(period_a), 10);
    repeat (5) step(1'b0);
    valid_count_a = 0;
    wave(5, 5, 3);
    check("restart_strobes", valid_count_a, 2);

    // Reset mid-count while locked
    wave(5, 5, 3);
    repeat (3) step(1'b1);
    do_reset();
    check("rst_period_a", int'(period_a), 0);
    check("rst_locked_a", int'(lk_a), 0);
    valid_count_a = 0;
    wave(5, 5, 3);
    check("post_reset_strobes", valid_count_a, 2);

    // Single-cycle glitch inside a 40-cycle period
    wave(20, 20, 2);
    repeat (20) step(1'b1);
    repeat (9) step(1'b0);
    step(1'b1);
    repeat (10) step(1'b0);
    check("glitch_period_b", int'(period_b), 29);
`ifdef HIGH_TIME_EN
    check("glitch_high_b", int'(high_b), 20);
`endif
    wave(20, 20, 2);
    check("after_glitch_period_b", int'(period_b), 40);

    // Random waves, static holds and occasional resets against the model
    for (int r = 0; r < 25; r++) begin
      wave($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        bit v;
        v = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 40)) step(v);
      end
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
